// File: rtl/scoreboard_scan.sv
// 4-digit BCD hit counter with time-multiplexed one-hot digit scan for the
// segment muxes, active-low anodes, selected-digit value and leading-zero blank.
//
// code  | meaning
// 0001  | units digit selected (never blanked)
// 0010  | tens digit selected
// 0100  | hundreds digit selected
// 1000  | thousands digit selected
module scoreboard_scan #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hit,
    input  logic       clear,
    output logic [3:0] code,
    output logic [3:0] anode,
    output logic [3:0] digit_val,
    output logic       blank,
    output logic       overflow
);

    localparam int            CW       = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);

    logic [15:0]   score_q, score_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            score_q <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            code_q  <= 4'b0001;
        end else begin
            score_q <= score_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
        end
    end

    // Score saturates at 9999 rather than wrapping; the sticky flag records the lost hit.
    always_comb begin
        score_d = score_q;
        ovf_d   = ovf_q;
        if (clear) begin
            score_d = '0;
            ovf_d   = 1'b0;
        end else if (hit) begin
            if (score_q == 16'h9999) begin
                ovf_d = 1'b1;
            end else begin
                score_d = bcd_inc(score_q);
            end
        end
    end

    always_comb begin
        cnt_d  = cnt_q + CW'(1);
        code_d = code_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            code_d = {code_q[2:0], code_q[3]};
        end
    end

    // Blank a digit only when it and every more significant digit are zero.
    always_comb begin
        digit_val = 4'd0;
        blank     = 1'b0;
        case (code_q)
            4'b0001: digit_val = score_q[3:0];
            4'b0010: begin
                digit_val = score_q[7:4];
                blank     = (score_q[15:4] == 12'd0);
            end
            4'b0100: begin
                digit_val = score_q[11:8];
                blank     = (score_q[15:8] == 8'd0);
            end
            4'b1000: begin
                digit_val = score_q[15:12];
                blank     = (score_q[15:12] == 4'd0);
            end
            default: begin
                digit_val = 4'd0;
                blank     = 1'b0;
            end
        endcase
    end

    assign code     = code_q;
    assign anode    = ~code_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_scoreboard_scan.sv
// Bench for scoreboard_scan: integer-score reference model checked every cycle,
// directed scenarios with literal expectations, then randomized hit/clear/reset traffic.
module tb_scoreboard_scan;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hit = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] code, anode, digit_val;
    logic       blank, overflow;

    int tests = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    int m_score = 0;
    bit m_ovf = 1'b0;
    int m_cnt = 0;
    int m_dig = 0;
    int p10[4] = '{1, 10, 100, 1000};

    logic [3:0] e_code, e_anode, e_val;
    logic       e_blank;

    scoreboard_scan #(.REFRESH_DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hit       (hit),
        .clear     (clear),
        .code      (code),
        .anode     (anode),
        .digit_val (digit_val),
        .blank     (blank),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: score as a plain integer, scan position as digit index + dwell count.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_score = 0;
            m_ovf   = 1'b0;
            m_cnt   = 0;
            m_dig   = 0;
        end else begin
            if (clear) begin
                m_score = 0;
                m_ovf   = 1'b0;
            end else if (hit) begin
                if (m_score == 9999) m_ovf = 1'b1;
                else m_score = m_score + 1;
            end
            if (m_cnt == DIV - 1) begin
                m_cnt = 0;
                m_dig = (m_dig + 1) % 4;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            e_code  = 4'(1 << m_dig);
            e_anode = ~e_code;
            e_val   = 4'((m_score / p10[m_dig]) % 10);
            e_blank = (m_dig > 0) && (m_score < p10[m_dig]);
            chk("code", {12'd0, code}, {12'd0, e_code});
            chk("anode", {12'd0, anode}, {12'd0, e_anode});
            chk("onehot", {15'd0, $onehot(code)}, 16'd1);
            chk("digit_val", {12'd0, digit_val}, {12'd0, e_val});
            chk("digit_le9", {15'd0, (digit_val <= 4'd9)}, 16'd1);
            chk("blank", {15'd0, blank}, {15'd0, e_blank});
            chk("overflow", {15'd0, overflow}, {15'd0, m_ovf});
        end
    end

    task automatic wait_digit(input int k);
        logic [3:0] want;
        int n;
        want = 4'(1 << k);
        n = 0;
        while (code !== want && n < 4 * DIV + 2) begin
            @(negedge clk);
            n++;
        end
        if (code !== want) begin
            tests++;
            errors++;
            $display("FAIL wait_digit: got %0h expected %0h", code, want);
        end
    endtask

    task automatic hold_hit(input int n);
        hit = 1'b1;
        repeat (n) @(negedge clk);
        hit = 1'b0;
    endtask

    initial begin
        // Reset and a full scan frame at score 0000
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        rst_n  = 1'b1;
        for (int j = 0; j <= 16; j++) begin
            chk("frame_code", {12'd0, code}, {12'd0, 4'(1 << ((j / 4) % 4))});
            chk("frame_val", {12'd0, digit_val}, 16'd0);
            chk("frame_blank", {15'd0, blank}, {15'd0, ((j / 4) % 4) != 0});
            if (j == 0) chk("reset_anode", {12'd0, anode}, 16'h000e);
            @(negedge clk);
        end

        // Ten single-cycle pulses -> 0010
        repeat (10) begin
            hit = 1'b1;
            @(negedge clk);
            hit = 1'b0;
            @(negedge clk);
        end
        wait_digit(1);
        chk("s10_tens", {12'd0, digit_val}, 16'd1);
        wait_digit(2);
        chk("s10_hund_blank", {15'd0, blank}, 16'd1);
        wait_digit(3);
        chk("s10_thou_blank", {15'd0, blank}, 16'd1);
        wait_digit(0);
        chk("s10_units", {12'd0, digit_val}, 16'd0);

        // Up to 0999 then ripple into 1000
        hold_hit(989);
        wait_digit(2);
        chk("s999_hund", {12'd0, digit_val}, 16'd9);
        hold_hit(1);
        wait_digit(3);
        chk("s1000_thou", {12'd0, digit_val}, 16'd1);
        chk("s1000_thou_blank", {15'd0, blank}, 16'd0);
        wait_digit(1);
        chk("s1000_tens", {12'd0, digit_val}, 16'd0);
        chk("s1000_tens_blank", {15'd0, blank}, 16'd0);

        // Saturation at 9999 and sticky overflow
        hold_hit(8999);
        wait_digit(3);
        chk("s9999_thou", {12'd0, digit_val}, 16'd9);
        chk("pre_ovf", {15'd0, overflow}, 16'd0);
        hit = 1'b1;
        @(negedge clk);
        chk("ovf_set", {15'd0, overflow}, 16'd1);
        repeat (2) @(negedge clk);
        hit = 1'b0;
        wait_digit(0);
        chk("sat_units", {12'd0, digit_val}, 16'd9);
        chk("ovf_sticky", {15'd0, overflow}, 16'd1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("ovf_cleared", {15'd0, overflow}, 16'd0);
        wait_digit(3);
        chk("clr_thou_blank", {15'd0, blank}, 16'd1);

        // clear beats hit
        hold_hit(5);
        clear = 1'b1;
        hit   = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        @(negedge clk);
        hit = 1'b0;
        wait_digit(0);
        chk("clr_prio_units", {12'd0, digit_val}, 16'd1);

        // Reset mid-dwell on hundreds with score 0123
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        hold_hit(123);
        wait_digit(1);
        wait_digit(2);
        chk("s123_hund", {12'd0, digit_val}, 16'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_code", {12'd0, code}, 16'd1);
        chk("rst_val", {12'd0, digit_val}, 16'd0);
        chk("rst_ovf", {15'd0, overflow}, 16'd0);
        for (int j = 1; j < DIV; j++) begin
            @(negedge clk);
            chk("rst_dwell", {12'd0, code}, 16'd1);
        end
        @(negedge clk);
        chk("rst_rotate", {12'd0, code}, 16'd2);

        // Random traffic from zero, including occasional resets
        for (int i = 0; i < 3000; i++) begin
            clear = ($urandom_range(0, 49) == 0);
            hit   = $urandom_range(0, 1);
            rst_n = ($urandom_range(0, 299) != 0);
            @(negedge clk);
        end
        rst_n = 1'b1;
        hit   = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;

        // Random traffic around the saturation point
        hold_hit(9990);
        for (int i = 0; i < 300; i++) begin
            clear = ($urandom_range(0, 199) == 0);
            hit   = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        clear = 1'b0;
        hit   = 1'b0;
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/scoreboard_scan.md
Name: scoreboard_scan

Overview:
- Upstream feeder for the scoreboard's per-segment 4-to-1 one-hot AND-OR digit multiplexers.
- Holds the game score as a 4-digit BCD counter. Increments on each hit pulse. Time-multiplexes the four digits onto the display.
- Produces the one-hot digit-select code shared by the segment muxes, the matching active-low anode drives, the BCD value of the selected digit and a leading-zero blank flag.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit stays selected; legal range >= 2.

Ports:
clk  in  1  system clock; all state updates on rising edge.
rst_n  in  1  synchronous reset, active-low; sampled on rising edge of clk.
hit  in  1  score increment request; adds 1 per cycle it is high.
clear  in  1  synchronous score clear; priority over hit.
code  out  4  one-hot digit select; bit0 = units, bit3 = thousands; drives the segment muxes.
anode  out  4  active-low anode enables; always equal to ~code.
digit_val  out  4  BCD value (0-9) of the digit selected by code.
blank  out  1  1 when the selected digit is a suppressed leading zero.
overflow  out  1  sticky; set when hit arrives with score at 9999.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - score = 0000 BCD; refresh counter = 0; code = 4'b0001.
  - anode = 4'b1110; overflow = 0; digit_val = 0; blank = 0.
  - Reset overrides clear and hit in the same cycle.
  - Reset mid-scan restarts at units digit with a full REFRESH_DIV dwell.
- Score register: four BCD nibbles d3..d0, each always in 0-9.
- Per-edge priority, with rst_n=1: clear > hit > hold.
  - clear=1: score = 0000, overflow = 0; hit ignored that cycle.
  - hit=1, score < 9999: BCD +1 with ripple carry. A nibble at 9 wraps to 0 and carries into the next nibble. Never produces nibble values A-F.
  - hit=1, score = 9999: score saturates, unchanged; overflow = 1.
  - Latency: the new score is visible on digit_val one cycle after the hit edge, provided that digit is selected.
- hit is level-sensitive; holding it high N cycles adds N. Edge detection is the caller's job.
- Refresh counter: counts 0..REFRESH_DIV-1, wraps to 0.
  - On the edge where the counter is at REFRESH_DIV-1, code rotates left: 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - Each digit is selected for exactly REFRESH_DIV cycles; full frame = 4*REFRESH_DIV cycles.
  - clear and hit never disturb the refresh counter or code.
- code is registered and always exactly one-hot. Any non-one-hot value is a design error and must be assertable in verification.
- anode = ~code, combinational from the code register.
- digit_val is combinational from code and score: code[i]=1 selects nibble d_i.
- blank is combinational:
  - code[0] selected: blank = 0 (units always shown).
  - code[k] selected, k >= 1: blank = 1 iff d_k and every higher digit are all 0.
  - Examples: score 0042 blanks thousands and hundreds only. Score 0000 blanks all except units. Score 1000 blanks none.
- overflow is cleared only by clear or reset.

Test Plan:
- Reset then release, REFRESH_DIV=4 -> code = 0001, anode = 1110 for 4 cycles. Then 0010, 0100, 1000, back to 0001 at cycle 16. digit_val = 0 throughout; blank = 0,1,1,1 per digit.
- 10 single-cycle hit pulses from 0 -> score 0010. Units digit_val = 0, tens = 1, hundreds and thousands blank = 1.
- Preload to 0999 via 999 hits, then one hit -> score 1000. No nibble ever reads > 9; blank = 0 on all digits.
- At 9999, assert hit 3 cycles -> score stays 9999, overflow = 1 from the cycle after the first hit. Then clear -> score 0000, overflow = 0.
- clear and hit high in the same cycle at score 0005 -> score 0000. Next cycle hit alone -> 0001.
- rst_n low for one edge mid-dwell on the hundreds digit, with score 0123 -> code = 0001, score 0000, overflow 0 on the next cycle. The next rotation occurs exactly REFRESH_DIV cycles later.
